// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: W-bit add sequenced LSB-first through one external N-bit slice adder
// Optional signed overflow flag under macro WADD_SEQ_OVF_EN
module wide_add_sequencer #(
  parameter int W = 64,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);
  localparam int CHUNKS = W / N;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CHUNKS-1:0][N-1:0] r_a, r_b, r_sum;
  logic r_cin, r_carry, w_last;
  assign w_last = r_cnt == CW'(CHUNKS - 1);
  always_comb begin
    w_next = (r_state == IDLE && in_valid) ? RUN :
             (r_state == RUN && w_last) ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
    in_ready = (r_state == IDLE) && !rst;
    add_a = (r_state == RUN) ? r_a[r_cnt] : '0;
    add_b = (r_state == RUN) ? r_b[r_cnt] : '0;
    add_cin = (r_state == RUN) && ((r_cnt == '0) ? r_cin : r_carry);
    out_valid = r_state == DONE;
    out_sum = r_sum;
    out_cout = out_valid && r_carry;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
`ifdef WADD_SEQ_OVF_EN
  logic r_ovf;
  assign out_ovf = out_valid && r_ovf;
`else
  assign out_ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_cin <= 1'b0;
      r_carry <= 1'b0;
`ifdef WADD_SEQ_OVF_EN
      r_ovf <= 1'b0;
`endif
    end else if (r_state == IDLE && in_valid) begin
      r_cnt <= '0;
      r_a <= in_a;
      r_b <= in_b;
      r_cin <= in_cin;
    end else if (r_state == RUN) begin
      r_sum[r_cnt] <= add_s;
      r_carry <= add_cout;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
`ifdef WADD_SEQ_OVF_EN
      // sign of the result comes straight from the MSB slice on its pass
      if (w_last) r_ovf <= (r_a[CHUNKS-1][N-1] == r_b[CHUNKS-1][N-1]) && (add_s[N-1] != r_a[CHUNKS-1][N-1]);
`endif
    end
  end
endmodule
